bus_responder: RTL and testbench
================================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter LATENCY, default 2, cycles from request acceptance to data_ok; legal range 1..15.
REQ-002 Parameter DEPTH_LOG2, default 12, log2 of the number of 64-bit memory words.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 ireq  input  ibus_req_t  instruction request: valid(1), addr(64).
REQ-006 iresp  output  ibus_resp_t  instruction response: addr_ok(1), data_ok(1), data(32).
REQ-007 dreq  input  dbus_req_t  data request: valid(1), addr(64), size(msize_t, 3), strobe(8), data(64).
REQ-008 dresp  output  dbus_resp_t  data response: addr_ok(1), data_ok(1), data(64).

Function
REQ-009 The block SHALL model a single-ported memory of 2^DEPTH_LOG2 64-bit words, indexed by addr[DEPTH_LOG2+2:3]; upper address bits are ignored, so out-of-range indices wrap modulo depth.
REQ-010 The block SHALL use an FSM with states IDLE, WAIT.
REQ-011 In IDLE, dreq.valid=1 SHALL grant D; otherwise ireq.valid=1 grants I; both valid in the same cycle -> D wins and I stays pending.
REQ-012 On grant, the block SHALL pulse the granted port's addr_ok for exactly that cycle, latch addr/size/strobe/data and the port id, load cnt=LATENCY-1, and go to WAIT.
REQ-013 In WAIT with cnt!=0, cnt SHALL decrement by 1 per cycle; no addr_ok or data_ok is asserted.
REQ-014 In WAIT with cnt==0, the block SHALL assert the owning port's data_ok for exactly one cycle and return to IDLE; data_ok therefore arrives exactly LATENCY cycles after the grant cycle.
REQ-015 On a D read (strobe==0), dresp.data SHALL equal the full aligned 64-bit word at the latched index during the data_ok cycle; byte/halfword/word extraction is done by the requester.
REQ-016 On a D write (strobe!=0), byte lane k SHALL be written from data[8k+7:8k] for each strobe[k]=1 at the data_ok edge; other lanes are unchanged; dresp.data carries the pre-write word.
REQ-017 On an I read, iresp.data SHALL equal word[31:0] when addr[2]=0, else word[63:32].
REQ-018 data_ok and addr_ok of the non-owning port SHALL be 0 at all times; data outputs SHALL be 0 whenever their data_ok is 0.
REQ-019 Once granted, a transaction SHALL complete even if valid deasserts or the request fields change in WAIT; latched values are used.
REQ-020 A request still valid in the cycle after data_ok SHALL be treated as a new request (re-arbitrated in IDLE); back-to-back throughput is one transaction per LATENCY+1 cycles.
REQ-021 A pending I request SHALL be starved only while D requests are continuously valid in IDLE cycles; no fairness beyond D priority is required.

Reset
REQ-022 On reset, the FSM SHALL enter IDLE and clear cnt, the latched request, and all addr_ok/data_ok/data outputs to 0 in the following cycle.
REQ-023 Reset during WAIT SHALL abort the transaction: no data_ok is emitted and a pending write is NOT committed.
REQ-024 Memory contents SHALL NOT be cleared by reset; the bench preloads them through a backdoor.

Verification
REQ-025 LATENCY=2, word[0]=0x1122334455667788, ireq valid addr 0x8000_0004 -> iresp.addr_ok at cycle 0, data_ok at cycle 2 with data 0x11223344.
REQ-026 dreq write addr 0x8000_0008, strobe 0x0F, data 0xAAAA_BBBB_CCCC_DDDD, word[1]=0 -> data_ok at cycle 2; subsequent read returns 0x0000_0000_CCCC_DDDD.
REQ-027 ireq and dreq both valid in the same IDLE cycle -> dresp.addr_ok first, then iresp.addr_ok in the cycle after dresp.data_ok; iresp data_ok LATENCY cycles later.
REQ-028 Write granted, reset asserted in WAIT before data_ok -> no data_ok on either port; target word keeps its old value.
REQ-029 LATENCY=1, ireq held valid continuously with PC stepping +4 after each data_ok -> data_ok every 2 cycles with the correct instruction words.
REQ-030 addr 0x8000_0000 + (1<<(DEPTH_LOG2+3)) -> aliases word[0].

Source files
------------

// File: rtl/bus_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bus_responder
//
// Fixed-latency memory responder. It serves an instruction port (read-only,
// 32-bit data) and a data port (64-bit read/write with byte strobes). Both
// ports share one single-ported memory of 2^DEPTH_LOG2 64-bit words. Only one
// transaction is in flight at a time.
//
// Parameters
//   LATENCY    : cycles from the grant (addr_ok) to data_ok, 1..15
//   DEPTH_LOG2 : log2 of the number of 64-bit words
//
// Ports
//   clk, reset                      : clock, synchronous active-high reset
//   ireq_valid, ireq_addr           : instruction request
//   iresp_addr_ok/data_ok/data      : instruction response (32-bit data)
//   dreq_valid/addr/size/strobe/data: data request (strobe==0 means read)
//   dresp_addr_ok/data_ok/data      : data response (64-bit data)
//
// Arbitration: in IDLE the data port wins over the instruction port. A grant
// pulses addr_ok for that cycle, latches the request and starts a countdown.
// data_ok is emitted LATENCY cycles after the grant; the next grant can happen
// in the cycle after data_ok. Memory contents survive reset.
// -----------------------------------------------------------------------------
module bus_responder #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t                state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;

    // Latched request
    logic                  owner_d_reg;
    logic [63:0]           addr_reg;
    logic [2:0]            size_reg;
    logic [7:0]            strobe_reg;
    logic [63:0]           wdata_reg;

    // Memory and its registered read port
    logic [63:0]           mem [DEPTH];
    logic [63:0]           rd_data_reg;
    logic [63:0]           merged_word;

    logic                  grant_d;
    logic                  grant_i;
    logic                  grant;
    logic                  done;
    logic                  write_en;
    logic [DEPTH_LOG2-1:0] grant_idx;
    logic [DEPTH_LOG2-1:0] latched_idx;

    // Reset gates every handshake so nothing is granted or completed (and no
    // write commits) while reset is held.
    assign grant_d  = (state_reg == IDLE) && dreq_valid && !reset;
    assign grant_i  = (state_reg == IDLE) && !dreq_valid && ireq_valid && !reset;
    assign grant    = grant_d || grant_i;
    assign done     = (state_reg == WAIT) && (cnt_reg == 4'd0) && !reset;
    assign write_en = done && owner_d_reg && (strobe_reg != 8'd0);

    // Upper address bits are dropped, so indices wrap modulo the depth.
    assign grant_idx   = grant_d ? dreq_addr[DEPTH_LOG2+2:3] : ireq_addr[DEPTH_LOG2+2:3];
    assign latched_idx = addr_reg[DEPTH_LOG2+2:3];

    // Next-state and countdown
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (grant) begin
                    state_next = WAIT;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            owner_d_reg <= 1'b0;
            addr_reg    <= 64'd0;
            size_reg    <= 3'd0;
            strobe_reg  <= 8'd0;
            wdata_reg   <= 64'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (grant_d) begin
                owner_d_reg <= 1'b1;
                addr_reg    <= dreq_addr;
                size_reg    <= dreq_size;
                strobe_reg  <= dreq_strobe;
                wdata_reg   <= dreq_data;
            end else if (grant_i) begin
                owner_d_reg <= 1'b0;
                addr_reg    <= ireq_addr;
                size_reg    <= 3'd0;
                strobe_reg  <= 8'd0;
                wdata_reg   <= 64'd0;
            end
        end
    end

    // The word is read at the grant edge and held until data_ok. Only the
    // owning transaction can write, and it does so at its own data_ok edge, so
    // the held copy is exactly the pre-write word the response must carry.
    // Writes are a read-modify-write of that copy, one full word per commit.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign merged_word[8*gi +: 8] = strobe_reg[gi] ? wdata_reg[8*gi +: 8]
                                                       : rd_data_reg[8*gi +: 8];
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            rd_data_reg <= mem[grant_idx];
        end
        if (write_en) begin
            mem[latched_idx] <= merged_word;
        end
    end

    // Responses
    always_comb begin
        dresp_addr_ok = grant_d;
        iresp_addr_ok = grant_i;
        dresp_data_ok = done && owner_d_reg;
        iresp_data_ok = done && !owner_d_reg;
        dresp_data    = 64'd0;
        iresp_data    = 32'd0;
        if (dresp_data_ok) begin
            dresp_data = rd_data_reg;
        end
        if (iresp_data_ok) begin
            iresp_data = addr_reg[2] ? rd_data_reg[63:32] : rd_data_reg[31:0];
        end
    end

    // Size is kept with the request for completeness but the requester does
    // any sub-word extraction; address bits outside the index are don't-care.
    logic unused_bits;
    assign unused_bits = ^{dreq_addr, ireq_addr, addr_reg, size_reg};

endmodule

// File: tb/tb_bus_responder.sv
`timescale 1ns/1ps
module tb_bus_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Instance A: LATENCY=2
    logic        a_ireq_valid, a_iresp_addr_ok, a_iresp_data_ok;
    logic [63:0] a_ireq_addr;
    logic [31:0] a_iresp_data;
    logic        a_dreq_valid, a_dresp_addr_ok, a_dresp_data_ok;
    logic [63:0] a_dreq_addr, a_dreq_data, a_dresp_data;
    logic [2:0]  a_dreq_size;
    logic [7:0]  a_dreq_strobe;

    // Instance B: LATENCY=1
    logic        b_ireq_valid, b_iresp_addr_ok, b_iresp_data_ok;
    logic [63:0] b_ireq_addr;
    logic [31:0] b_iresp_data;
    logic        b_dreq_valid, b_dresp_addr_ok, b_dresp_data_ok;
    logic [63:0] b_dreq_addr, b_dreq_data, b_dresp_data;
    logic [2:0]  b_dreq_size;
    logic [7:0]  b_dreq_strobe;

    bus_responder #(.LATENCY(2), .DEPTH_LOG2(12)) u_a (
        .clk(clk), .reset(reset),
        .ireq_valid(a_ireq_valid), .ireq_addr(a_ireq_addr),
        .iresp_addr_ok(a_iresp_addr_ok), .iresp_data_ok(a_iresp_data_ok), .iresp_data(a_iresp_data),
        .dreq_valid(a_dreq_valid), .dreq_addr(a_dreq_addr), .dreq_size(a_dreq_size),
        .dreq_strobe(a_dreq_strobe), .dreq_data(a_dreq_data),
        .dresp_addr_ok(a_dresp_addr_ok), .dresp_data_ok(a_dresp_data_ok), .dresp_data(a_dresp_data)
    );

    bus_responder #(.LATENCY(1), .DEPTH_LOG2(12)) u_b (
        .clk(clk), .reset(reset),
        .ireq_valid(b_ireq_valid), .ireq_addr(b_ireq_addr),
        .iresp_addr_ok(b_iresp_addr_ok), .iresp_data_ok(b_iresp_data_ok), .iresp_data(b_iresp_data),
        .dreq_valid(b_dreq_valid), .dreq_addr(b_dreq_addr), .dreq_size(b_dreq_size),
        .dreq_strobe(b_dreq_strobe), .dreq_data(b_dreq_data),
        .dresp_addr_ok(b_dresp_addr_ok), .dresp_data_ok(b_dresp_data_ok), .dresp_data(b_dresp_data)
    );

    typedef struct {
        bit          is_d;
        logic [63:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Drive one single-port request on A for the grant cycle, capture the
    // addr_ok pair, then drop valid and scramble the fields during WAIT.
    task automatic a_issue(input bit is_d, input logic [63:0] addr, input logic [7:0] strobe,
                           input logic [63:0] wdata, output bit iaok, output bit daok);
        @(posedge clk); #1;
        if (is_d) begin
            a_dreq_valid  = 1'b1;
            a_dreq_addr   = addr;
            a_dreq_size   = 3'd3;
            a_dreq_strobe = strobe;
            a_dreq_data   = wdata;
        end else begin
            a_ireq_valid = 1'b1;
            a_ireq_addr  = addr;
        end
        @(negedge clk);
        iaok = a_iresp_addr_ok;
        daok = a_dresp_addr_ok;
        @(posedge clk); #1;
        a_ireq_valid  = 1'b0;
        a_dreq_valid  = 1'b0;
        a_ireq_addr   = '1;
        a_dreq_addr   = 64'h8000_0000;
        a_dreq_strobe = 8'hFF;
        a_dreq_data   = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    // Count cycles after a grant until a data_ok appears on A; flag any
    // handshake or nonzero data seen while waiting.
    task automatic a_wait(input int budget, output int cyc, output bit got, output bit is_d,
                          output logic [63:0] data, output bit leak);
        cyc = 0; got = 1'b0; is_d = 1'b0; data = 64'd0; leak = 1'b0;
        while (!got && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (a_dresp_data_ok === 1'b1 || a_iresp_data_ok === 1'b1) begin
                got  = 1'b1;
                is_d = (a_dresp_data_ok === 1'b1);
                data = is_d ? a_dresp_data : {32'd0, a_iresp_data};
                if (a_dresp_data_ok === 1'b1 && a_iresp_data_ok === 1'b1) leak = 1'b1;
                if (a_dresp_addr_ok !== 1'b0 || a_iresp_addr_ok !== 1'b0) leak = 1'b1;
            end else if (a_dresp_data !== 64'd0 || a_iresp_data !== 32'd0 ||
                         a_dresp_addr_ok !== 1'b0 || a_iresp_addr_ok !== 1'b0) begin
                leak = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_ireq_valid = 1'b1; a_ireq_addr = 64'h8000_0000;
        a_dreq_valid = 1'b1; a_dreq_addr = 64'h8000_0000; a_dreq_size = 3'd3;
        a_dreq_strobe = 8'hFF; a_dreq_data = 64'h1;
        b_ireq_valid = 1'b0; b_ireq_addr = 64'd0;
        b_dreq_valid = 1'b0; b_dreq_addr = 64'd0; b_dreq_size = 3'd0;
        b_dreq_strobe = 8'd0; b_dreq_data = 64'd0;
        // Backdoor preload
        u_a.mem[0] = 64'h1122_3344_5566_7788;
        u_a.mem[1] = 64'h0;
        u_a.mem[2] = 64'h2222_2222_AAAA_0002;
        u_a.mem[3] = 64'h3333_3333_4444_4444;
        u_a.mem[5] = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 4; i++) begin
            u_b.mem[i] = {32'(32'h0BAD_0000 + 2 * i + 1), 32'(32'h0BAD_0000 + 2 * i)};
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if ({a_iresp_addr_ok, a_iresp_data_ok, a_iresp_data} !== 34'd0) begin
            tests_failed++;
            $display("FAIL reset_a_iresp: got %h, required 0", {a_iresp_addr_ok, a_iresp_data_ok, a_iresp_data});
        end
        tests_run++;
        if ({a_dresp_addr_ok, a_dresp_data_ok, a_dresp_data} !== 66'd0) begin
            tests_failed++;
            $display("FAIL reset_a_dresp: got %h, required 0", {a_dresp_addr_ok, a_dresp_data_ok, a_dresp_data});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        a_ireq_valid = 1'b0; a_dreq_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({a_iresp_addr_ok, a_iresp_data_ok, a_dresp_addr_ok, a_dresp_data_ok,
             b_iresp_addr_ok, b_iresp_data_ok, b_dresp_addr_ok, b_dresp_data_ok} !== 8'd0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: handshakes %b, required 00000000",
                     {a_iresp_addr_ok, a_iresp_data_ok, a_dresp_addr_ok, a_dresp_data_ok,
                      b_iresp_addr_ok, b_iresp_data_ok, b_dresp_addr_ok, b_dresp_data_ok});
        end
        $display("[TB] reset done");
    endtask

    // Single-port transactions on A: instruction reads, data reads/writes, aliasing.
    task automatic run_single(input string name, input bit is_d, input logic [63:0] addr,
                              input logic [7:0] strobe, input logic [63:0] wdata,
                              input logic [63:0] expect_data);
        bit iaok, daok, got, is_d_obs, leak;
        int cyc;
        logic [63:0] data;
        exp_t e;
        sb_q.push_back('{is_d: is_d, data: expect_data});
        a_issue(is_d, addr, strobe, wdata, iaok, daok);
        a_wait(8, cyc, got, is_d_obs, data, leak);
        tests_run++;
        if ({iaok, daok} !== {!is_d, is_d}) begin
            tests_failed++;
            $display("FAIL %s_addr_ok: got i=%b d=%b, required i=%b d=%b", name, iaok, daok, !is_d, is_d);
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s_timeout: got no data_ok in 8 cycles, required one at cycle 2", name);
            void'(sb_q.pop_front());
            return;
        end
        e = sb_q.pop_front();
        tests_run++;
        if (cyc !== 2) begin
            tests_failed++;
            $display("FAIL %s_latency: got data_ok at cycle %0d, required 2", name, cyc);
        end
        tests_run++;
        if (is_d_obs !== e.is_d || data !== e.data) begin
            tests_failed++;
            $display("FAIL %s_data: got d=%b %h, required d=%b %h", name, is_d_obs, data, e.is_d, e.data);
        end
        tests_run++;
        if (leak !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_quiet: got stray handshake/data while waiting, required none", name);
        end
        $display("[TB] %s addr=%h port=%s data=%h cyc=%0d", name, addr, is_d ? "D" : "I", data, cyc);
    endtask

    task automatic test_iread();
        run_single("iread_hi", 1'b0, 64'h8000_0004, 8'd0, 64'd0, 64'h0000_0000_1122_3344);
        run_single("iread_lo", 1'b0, 64'h8000_0000, 8'd0, 64'd0, 64'h0000_0000_5566_7788);
    endtask

    task automatic test_dwrite();
        run_single("dwrite", 1'b1, 64'h8000_0008, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0);
        run_single("dread_back", 1'b1, 64'h8000_0008, 8'h00, 64'h0, 64'h0000_0000_CCCC_DDDD);
        run_single("dwrite_hi", 1'b1, 64'h8000_0008, 8'hC0, 64'h5A5A_0000_0000_0000, 64'h0000_0000_CCCC_DDDD);
        run_single("dread_back2", 1'b1, 64'h8000_0008, 8'h00, 64'h0, 64'h5A5A_0000_CCCC_DDDD);
    endtask

    task automatic test_alias();
        run_single("alias_d", 1'b1, 64'h8000_0000 + (64'd1 << 15), 8'd0, 64'd0, 64'h1122_3344_5566_7788);
        run_single("alias_i", 1'b0, 64'h8000_0004 + (64'd1 << 15), 8'd0, 64'd0, 64'h0000_0000_1122_3344);
    endtask

    task automatic test_priority();
        bit got, is_d_obs, leak;
        int cyc;
        logic [63:0] data;
        exp_t e;
        @(posedge clk); #1;
        a_dreq_valid = 1'b1; a_dreq_addr = 64'h8000_0010; a_dreq_strobe = 8'd0; a_dreq_size = 3'd3;
        a_ireq_valid = 1'b1; a_ireq_addr = 64'h8000_001C;
        sb_q.push_back('{is_d: 1'b1, data: 64'h2222_2222_AAAA_0002});
        sb_q.push_back('{is_d: 1'b0, data: 64'h0000_0000_3333_3333});
        @(negedge clk);
        tests_run++;
        if ({a_dresp_addr_ok, a_iresp_addr_ok} !== 2'b10) begin
            tests_failed++;
            $display("FAIL prio_grant: got d=%b i=%b, required d=1 i=0", a_dresp_addr_ok, a_iresp_addr_ok);
        end
        @(posedge clk); #1;
        a_dreq_valid = 1'b0;
        a_wait(8, cyc, got, is_d_obs, data, leak);
        e = sb_q.pop_front();
        tests_run++;
        if (!got || cyc !== 2 || is_d_obs !== e.is_d || data !== e.data || leak !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_d_resp: got ok=%b cyc=%0d d=%b %h stray=%b, required ok=1 cyc=2 d=%b %h stray=0",
                     got, cyc, is_d_obs, data, leak, e.is_d, e.data);
        end
        $display("[TB] prio D data=%h cyc=%0d", data, cyc);
        @(negedge clk);
        tests_run++;
        if ({a_dresp_addr_ok, a_iresp_addr_ok} !== 2'b01) begin
            tests_failed++;
            $display("FAIL prio_i_grant: got d=%b i=%b, required d=0 i=1", a_dresp_addr_ok, a_iresp_addr_ok);
        end
        @(posedge clk); #1;
        a_ireq_valid = 1'b0;
        a_wait(8, cyc, got, is_d_obs, data, leak);
        e = sb_q.pop_front();
        tests_run++;
        if (!got || cyc !== 2 || is_d_obs !== e.is_d || data !== e.data || leak !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_i_resp: got ok=%b cyc=%0d d=%b %h stray=%b, required ok=1 cyc=2 d=%b %h stray=0",
                     got, cyc, is_d_obs, data, leak, e.is_d, e.data);
        end
        $display("[TB] prio I data=%h cyc=%0d", data, cyc);
    endtask

    task automatic test_reset_abort();
        bit iaok, daok;
        int seen = 0;
        a_issue(1'b1, 64'h8000_0028, 8'hFF, 64'hFEED_FACE_FEED_FACE, iaok, daok);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_dresp_data_ok !== 1'b0 || a_iresp_data_ok !== 1'b0) seen++;
            if (i == 1) begin
                @(posedge clk); #1;
                reset = 1'b0;
            end
        end
        tests_run++;
        if (daok !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_grant: got d_addr_ok=%b, required 1", daok);
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_data_ok: got %0d data_ok cycles, required 0", seen);
        end
        $display("[TB] abort write addr=8000_0028 data_ok_cycles=%0d", seen);
        run_single("abort_readback", 1'b1, 64'h8000_0028, 8'd0, 64'd0, 64'h0123_4567_89AB_CDEF);
    endtask

    // LATENCY=1 instruction stream: the fetcher steps the PC after each data_ok.
    task automatic test_back_to_back();
        logic [63:0] pc;
        int last_ok;
        exp_t e;
        pc = 64'h8000_0000;
        last_ok = 0;
        @(posedge clk); #1;
        b_ireq_valid = 1'b1;
        b_ireq_addr  = pc;
        for (int k = 0; k < 8; k++) begin
            sb_q.push_back('{is_d: 1'b0, data: {32'd0, 32'(32'h0BAD_0000 + k)}});
            @(negedge clk);
            tests_run++;
            if (b_iresp_addr_ok !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_addr_ok[%0d]: got %b, required 1", k, b_iresp_addr_ok);
            end
            @(negedge clk);
            e = sb_q.pop_front();
            tests_run++;
            if (b_iresp_data_ok !== 1'b1 || {32'd0, b_iresp_data} !== e.data) begin
                tests_failed++;
                $display("FAIL b2b_data[%0d]: got ok=%b %h, required ok=1 %h", k, b_iresp_data_ok, b_iresp_data, e.data[31:0]);
            end
            if (k > 0) begin
                tests_run++;
                if (cyc_cnt - last_ok !== 2) begin
                    tests_failed++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles, required 2", k, cyc_cnt - last_ok);
                end
            end
            last_ok = cyc_cnt;
            $display("[TB] b2b pc=%h instr=%h", pc, b_iresp_data);
            @(posedge clk); #1;
            pc = pc + 64'd4;
            b_ireq_addr = pc;
            if (k == 7) b_ireq_valid = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100us, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_iread();
        test_dwrite();
        test_priority();
        test_reset_abort();
        test_alias();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
